// File: rtl/syscall_display_unit.sv
// Queues CPU syscall display values and shows each on an 8-digit seven-segment scan for a minimum hold time.
// Push-to-display latency is one cycle when idle; pushes while full are dropped and flagged (full doubles as a stall request).
module syscall_display_unit #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int SCAN_DIV    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     syscall_valid,
    input  logic [31:0]              syscall_data,
    input  logic                     clear_ovf,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [31:0]              disp_value,
    output logic [7:0]               an,
    output logic [6:0]               seg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = 3 + $clog2(SCAN_DIV);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    state_t        r_state;
    logic [HW-1:0] r_hold;
    logic [31:0]   r_disp;
    logic [SW-1:0] r_scan;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [SW-1:0] w_scan_nxt;
    logic [2:0]    w_digit;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == COUNT_FULL);
    // The head leaves the FIFO whenever the display is ready for a new value.
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || (r_hold == '0));
    assign w_push  = syscall_valid && (!w_full || w_pop);
    assign w_drop  = syscall_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= syscall_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_disp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_disp  <= r_mem[r_rd_ptr];
                        r_hold  <= HOLD_RELOAD;
                        r_state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HW'(1);
                    end else if (!w_empty) begin
                        r_disp <= r_mem[r_rd_ptr];
                        r_hold <= HOLD_RELOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Digit select comes from the next counter value so an/seg land in the same register stage.
    assign w_scan_nxt = r_scan + SW'(1);
    assign w_digit    = w_scan_nxt[SW-1 -: 3];
    assign w_nib      = r_disp[{w_digit, 2'b00} +: 4];

    always_comb begin
        w_seg_nxt = 7'b1000000;
        case (w_nib)
            4'h0: w_seg_nxt = 7'b1000000;
            4'h1: w_seg_nxt = 7'b1111001;
            4'h2: w_seg_nxt = 7'b0100100;
            4'h3: w_seg_nxt = 7'b0110000;
            4'h4: w_seg_nxt = 7'b0011001;
            4'h5: w_seg_nxt = 7'b0010010;
            4'h6: w_seg_nxt = 7'b0000010;
            4'h7: w_seg_nxt = 7'b1111000;
            4'h8: w_seg_nxt = 7'b0000000;
            4'h9: w_seg_nxt = 7'b0010000;
            4'hA: w_seg_nxt = 7'b0001000;
            4'hB: w_seg_nxt = 7'b0000011;
            4'hC: w_seg_nxt = 7'b1000110;
            4'hD: w_seg_nxt = 7'b0100001;
            4'hE: w_seg_nxt = 7'b0000110;
            4'hF: w_seg_nxt = 7'b0001110;
            default: w_seg_nxt = 7'b1000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_an   <= 8'hFE;
            r_seg  <= 7'b1000000;
        end else begin
            r_scan <= w_scan_nxt;
            r_an   <= ~(8'b1 << w_digit);
            r_seg  <= w_seg_nxt;
        end
    end

    assign full       = w_full;
    assign overflow   = r_ovf;
    assign fifo_count = r_count;
    assign disp_value = r_disp;
    assign an         = r_an;
    assign seg        = r_seg;

endmodule

// File: tb/tb_syscall_display_unit.sv
// Directed bench: stimulus queues expected display values, a negedge monitor checks every change of disp_value.
module tb_syscall_display_unit;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int SDIV  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        syscall_valid = 1'b0;
    logic [31:0] syscall_data = '0;
    logic        clear_ovf = 1'b0;
    logic        full;
    logic        overflow;
    logic [2:0]  fifo_count;
    logic [31:0] disp_value;
    logic [7:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    syscall_display_unit #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .syscall_valid(syscall_valid), .syscall_data(syscall_data),
        .clear_ovf(clear_ovf), .full(full), .overflow(overflow), .fifo_count(fifo_count),
        .disp_value(disp_value), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive for one clock edge, return at the following negedge with outputs settled.
    task automatic step(input logic v, input logic [31:0] d, input logic c);
        syscall_valid = v;
        syscall_data  = d;
        clear_ovf     = c;
        @(negedge clk);
        syscall_valid = 1'b0;
        clear_ovf     = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (fifo_count != 0 && n < 300) begin
            step(0, 0, 0);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: count %0d expected 0", fifo_count);
        end
        repeat (HOLD + 2) step(0, 0, 0);
    endtask

    // Monitor: every change of disp_value must be the next queued value, at least HOLD cycles after the last.
    int          gap = 1000;
    logic [31:0] prev_disp = '0;
    logic [31:0] exp_v;
    always @(negedge clk) begin
        if (rst) begin
            prev_disp = '0;
            gap = 1000;
        end else begin
            gap++;
            if (disp_value !== prev_disp) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_disp: got %h expected no change from %h", disp_value, prev_disp);
                end else begin
                    exp_v = sb.pop_front();
                    if (disp_value !== exp_v) begin
                        fails++;
                        $display("FAIL disp_order: got %h expected %h", disp_value, exp_v);
                    end
                end
                tests++;
                if (gap < HOLD) begin
                    fails++;
                    $display("FAIL hold_time: got %0d cycles expected at least %0d", gap, HOLD);
                end
                prev_disp = disp_value;
                gap = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  prev_an;
    logic [31:0] obs [32];
    logic [6:0]  exp_seg [8];
    logic [7:0]  seen;
    int          run;
    int          nchg;
    int          seg_bad;

    initial begin
        exp_seg = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_disp", disp_value, 32'h0);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_an", an, 8'hFE);
        chk("rst_seg", seg, 7'b1000000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle scan: an rotates every SDIV cycles, all digits show "0"
        prev_an = an;
        run = 0; nchg = 0; seg_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0);
            run++;
            if (seg !== 7'b1000000) seg_bad++;
            if (an !== prev_an) begin
                chk("an_rotate", an, {prev_an[6:0], prev_an[7]});
                if (nchg > 0) chk("an_interval", run, SDIV);
                nchg++;
                run = 0;
                prev_an = an;
            end
        end
        chk("idle_seg_zero", seg_bad, 0);
        chk("idle_an_changes", nchg >= 5, 1);
        chk("idle_disp", disp_value, 0);
        chk("idle_count", fifo_count, 0);
        chk("idle_ovf", overflow, 0);

        // Single push: one-cycle latency, then per-digit glyphs
        sb.push_back(32'h1234ABCD);
        step(1, 32'h1234ABCD, 0);
        chk("lat_push_edge", disp_value, 32'h0);
        step(0, 0, 0);
        chk("lat_next_edge", disp_value, 32'h1234ABCD);
        seen = '0;
        for (int i = 0; i < 140; i++) begin
            step(0, 0, 0);
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'b1 << d) && !seen[d]) begin
                    seen[d] = 1'b1;
                    chk($sformatf("seg_digit%0d", d), seg, exp_seg[d]);
                end
            end
        end
        chk("digits_seen", seen, 8'hFF);

        // Back-to-back 1,2,3: HOLD cycles each, no gap
        sb.push_back(1); sb.push_back(2); sb.push_back(3);
        for (int i = 0; i < 32; i++) begin
            step(i < 3, i + 1, 0);
            obs[i] = disp_value;
        end
        chk("b2b_first", obs[1], 1);
        chk("b2b_first_end", obs[8], 1);
        chk("b2b_second", obs[9], 2);
        chk("b2b_second_end", obs[16], 2);
        chk("b2b_third", obs[17], 3);
        chk("b2b_third_hold", obs[31], 3);
        sb.push_back(7);
        step(1, 7, 0);
        step(0, 0, 0);
        chk("back_to_idle_latency", disp_value, 7);
        wait_drain();

        // Burst of DEPTH+3: 15 and 16 dropped; clear_ovf with a drop keeps the flag
        for (int v = 10; v <= 14; v++) sb.push_back(v);
        for (int v = 10; v <= 14; v++) step(1, v, 0);
        chk("burst_full", full, 1);
        chk("burst_count", fifo_count, 4);
        chk("burst_ovf_before", overflow, 0);
        step(1, 15, 0);
        chk("burst_ovf_set", overflow, 1);
        step(1, 16, 1);
        chk("ovf_set_wins", overflow, 1);
        chk("burst_count_after_drop", fifo_count, 4);
        wait_drain();
        chk("burst_last_disp", disp_value, 14);
        step(0, 0, 1);
        chk("ovf_clear", overflow, 0);

        // Full FIFO, push on the pop cycle is accepted
        for (int v = 20; v <= 25; v++) sb.push_back(v);
        for (int v = 20; v <= 24; v++) step(1, v, 0);
        chk("fill_full", full, 1);
        repeat (4) step(0, 0, 0);
        chk("fill_still_full", fifo_count, 4);
        step(1, 25, 0);
        chk("pop_push_count", fifo_count, 4);
        chk("pop_push_ovf", overflow, 0);
        chk("pop_push_disp", disp_value, 21);
        wait_drain();
        chk("pop_push_last", disp_value, 25);

        // Reset mid-SHOW with two entries queued
        sb.push_back(30);
        step(1, 30, 0);
        step(1, 31, 0);
        step(1, 32, 0);
        chk("pre_rst_disp", disp_value, 30);
        chk("pre_rst_count", fifo_count, 2);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_disp", disp_value, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_an", an, 8'hFE);
        chk("mid_rst_seg", seg, 7'b1000000);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (40) step(0, 0, 0);
        chk("post_rst_disp", disp_value, 0);
        chk("post_rst_count", fifo_count, 0);
        sb.push_back(32'h55);
        step(1, 32'h55, 0);
        step(0, 0, 0);
        chk("post_rst_push", disp_value, 32'h55);
        wait_drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
